// File: rtl/quan_skew_regs_act.sv
// Input-side skew buffer: lane r of each activation row is delayed by r+1 enabled cycles.
// Optional SKEW_ZERO_FILL_EN forces data to zero on every invalid beat.
module quan_skew_regs_act #(
  parameter int unsigned row_num_in_sa  = 16,
  parameter int unsigned lane_width     = 16,
  parameter int unsigned tile_cnt_width = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en,
  output logic                                in_ready,
  input  logic                                in_valid,
  input  logic                                in_last,
  input  logic [lane_width*row_num_in_sa-1:0] act_row,
  output logic [lane_width*row_num_in_sa-1:0] skew_act_row,
  output logic [row_num_in_sa-1:0]            skew_valid,
  output logic [row_num_in_sa-1:0]            skew_last,
  output logic                                busy,
  output logic                                drain_done
);

  localparam int unsigned R = row_num_in_sa;
  localparam int unsigned W = lane_width;
  localparam logic [tile_cnt_width-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                    state_q, state_d;
  logic [tile_cnt_width-1:0] cnt_q, cnt_d;
  logic                      busy_q, busy_d;
  logic                      drain_done_q, drain_done_d;
  logic                      accept, last_in, tail_last_d;

  assign in_ready = en;
  assign accept   = in_valid & en;
  assign last_in  = in_last & accept;

  for (genvar r = 0; r < R; r++) begin : g_lane
    logic [r:0][W-1:0] data_q, data_d;
    logic [r:0]        valid_q, valid_d, last_q, last_d;

    always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      if (en) begin
        data_d[0]  = act_row[r*W +: W];
        valid_d[0] = accept;
        last_d[0]  = last_in;
        for (int s = 1; s <= r; s++) begin
          data_d[s]  = data_q[s-1];
          valid_d[s] = valid_q[s-1];
          last_d[s]  = last_q[s-1];
        end
`ifdef SKEW_ZERO_FILL_EN
        for (int s = 0; s <= r; s++) begin
          if (!valid_d[s]) data_d[s] = '0;
        end
`endif
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        data_q  <= '0;
        valid_q <= '0;
        last_q  <= '0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
        last_q  <= last_d;
      end
    end

    assign skew_act_row[r*W +: W] = data_q[r];
    assign skew_valid[r]          = valid_q[r];
    assign skew_last[r]           = last_q[r];

    if (r == R - 1) begin : g_tail
      assign tail_last_d = last_d[r];
    end
  end

  // Pulse rides alongside skew_last[R-1]; masked while stalled so it is consumed once.
  assign drain_done_d = tail_last_d;
  assign drain_done   = drain_done_q & en;

  always_comb begin
    cnt_d = cnt_q;
    if (last_in && !drain_done && cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end else if (drain_done && !last_in && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) state_d = in_last ? StDrain : StRun;
      end
      StRun: begin
        if (accept && in_last) state_d = StDrain;
      end
      StDrain: begin
        if (accept) begin
          state_d = in_last ? StDrain : StRun;
        end else if (drain_done && cnt_d == '0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      drain_done_q <= drain_done_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_quan_skew_regs_act.sv
// Bench for quan_skew_regs_act: history-queue model checked every cycle plus directed
// literal checks for skew timing, stall, back-to-back tiles, reset and zero fill.
module tb_quan_skew_regs_act;

  localparam int R  = 16;
  localparam int W  = 16;
  localparam int DW = R * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          in_ready;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [DW-1:0] act_row = '0;
  logic [DW-1:0] skew_act_row;
  logic [R-1:0]  skew_valid;
  logic [R-1:0]  skew_last;
  logic          busy;
  logic          drain_done;

  int n_assert = 0;
  int n_fail   = 0;

  quan_skew_regs_act #(
    .row_num_in_sa (R),
    .lane_width    (W),
    .tile_cnt_width(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .in_ready    (in_ready),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .act_row     (act_row),
    .skew_act_row(skew_act_row),
    .skew_valid  (skew_valid),
    .skew_last   (skew_last),
    .busy        (busy),
    .drain_done  (drain_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: rows accepted on enabled cycles, newest at index 0. Lane r shows entry r.
  logic [DW-1:0] h_row [R];
  logic [R-1:0]  hv = '0;
  logic [R-1:0]  hl = '0;
  int            m_cnt = 0;
  bit            m_open = 1'b0;
  bit            chk_on = 1'b0;

  initial for (int i = 0; i < R; i++) h_row[i] = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < R; i++) h_row[i] = '0;
      hv = '0;
      hl = '0;
      m_cnt = 0;
      m_open = 1'b0;
      chk_on = 1'b1;
    end else if (en) begin
      if (in_valid && in_last && !hl[R-1] && m_cnt != 15) m_cnt++;
      else if (hl[R-1] && !(in_valid && in_last) && m_cnt != 0) m_cnt--;
      if (in_valid) m_open = !in_last;
      for (int i = R - 1; i > 0; i--) h_row[i] = h_row[i-1];
`ifdef SKEW_ZERO_FILL_EN
      h_row[0] = in_valid ? act_row : '0;
`else
      h_row[0] = act_row;
`endif
      hv = {hv[R-2:0], in_valid};
      hl = {hl[R-2:0], in_valid & in_last};
    end
  end

  always @(negedge clk) begin
    logic [DW-1:0] exp_row;
    if (chk_on) begin
      for (int r = 0; r < R; r++) exp_row[r*W +: W] = h_row[r][r*W +: W];
      check("m_skew_act_row", skew_act_row, exp_row);
      check("m_skew_valid", DW'(skew_valid), DW'(hv));
      check("m_skew_last", DW'(skew_last), DW'(hl));
      check("m_drain_done", DW'(drain_done), DW'(en & hl[R-1]));
      check("m_busy", DW'(busy), DW'(m_open || m_cnt != 0));
      check("m_in_ready", DW'(in_ready), DW'(en));
    end
  end

  task automatic drive(input logic v, input logic l, input logic e, input logic [DW-1:0] row);
    in_valid = v;
    in_last  = l;
    en       = e;
    act_row  = row;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mkrow(input logic [15:0] base);
    logic [DW-1:0] row;
    for (int r = 0; r < R; r++) row[r*W +: W] = base + 16'(r);
    return row;
  endfunction

  initial begin
    int c;
    int found;
    int n15;
    int p1;
    int p2;
    int ndd;
    int tb;
    logic [DW-1:0] ones;
    logic [DW-1:0] exp6;
    logic v;
    logic l;
    logic e;

    // Reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            {8{$urandom()}});
    end
    check("rst_act_row", skew_act_row, '0);
    check("rst_valid", DW'(skew_valid), '0);
    check("rst_last", DW'(skew_last), '0);
    check("rst_busy", DW'(busy), '0);
    check("rst_drain_done", DW'(drain_done), '0);
    rst_n = 1'b1;
    drive(0, 0, 1, '0);

    // Single-beat tile: lane r appears r+1 cycles later
    drive(1, 1, 1, mkrow(16'h0100));
    for (int k = 1; k <= 17; k++) begin
      if (k > 1) drive(0, 0, 1, '0);
      check("skew_valid_t", DW'(skew_valid), (k <= 16) ? (DW'(1) << (k - 1)) : '0);
      check("skew_last_t", DW'(skew_last), (k <= 16) ? (DW'(1) << (k - 1)) : '0);
      if (k <= 16) check("skew_data_t", DW'(skew_act_row[(k-1)*W +: W]), DW'(16'h0100 + k - 1));
      check("skew_drain_t", DW'(drain_done), DW'(k == 16));
      check("skew_busy_t", DW'(busy), DW'(k <= 16));
    end
    drive(0, 0, 1, '0);

    // Stall: 8 beats, 3 stalled cycles after beat 4
    c = 0;
    for (int b = 0; b < 4; b++) begin drive(1, 0, 1, mkrow(16'h0A00 + 16'(b << 8))); c++; end
    for (int s = 0; s < 3; s++) begin drive(1, 0, 0, mkrow(16'h0E00)); c++; end
    for (int b = 4; b < 8; b++) begin
      drive(1, b == 7, 1, mkrow(16'h0A00 + 16'(b << 8)));
      c++;
    end
    found = -1;
    n15 = 0;
    for (int i = 0; i < 80 && found < 0; i++) begin
      if (skew_valid[15]) n15++;
      if (drain_done) found = c;
      else begin drive(0, 0, 1, '0); c++; end
    end
    check("stall_drain_cycle", DW'(found), DW'(26));
    check("stall_lane15_beats", DW'(n15), DW'(8));
    for (int i = 0; i < 3; i++) drive(0, 0, 1, '0);

    // Back-to-back tiles
    c = 0;
    for (int b = 0; b < 8; b++) begin
      drive(1, b == 3 || b == 7, 1, mkrow(16'h2000 + 16'(b << 8)));
      c++;
    end
    p1 = -1;
    p2 = -1;
    for (int i = 0; i < 60 && p2 < 0; i++) begin
      check("b2b_busy", DW'(busy), DW'(1));
      if (drain_done) begin
        if (p1 < 0) p1 = c;
        else p2 = c;
      end
      if (p2 < 0) begin drive(0, 0, 1, '0); c++; end
    end
    check("b2b_first_pulse", DW'(p1), DW'(19));
    check("b2b_second_pulse", DW'(p2), DW'(23));
    drive(0, 0, 1, '0);
    check("b2b_busy_after", DW'(busy), '0);

    // Reset mid-tile
    for (int b = 0; b < 4; b++) drive(1, 0, 1, mkrow(16'h3000 + 16'(b << 8)));
    rst_n = 1'b0;
    drive(1, 0, 1, mkrow(16'h3400));
    rst_n = 1'b1;
    check("midrst_valid", DW'(skew_valid), '0);
    check("midrst_last", DW'(skew_last), '0);
    check("midrst_busy", DW'(busy), '0);
    ndd = 0;
    for (int i = 0; i < 40; i++) begin
      drive(0, 0, 1, '0);
      if (drain_done) ndd++;
    end
    check("midrst_no_drain", DW'(ndd), '0);

    // Invalid beats carrying all-ones data
    ones = '1;
    for (int i = 0; i < 17; i++) drive(0, 0, 1, ones);
`ifdef SKEW_ZERO_FILL_EN
    exp6 = '0;
`else
    exp6 = ones;
`endif
    check("fill_data", skew_act_row, exp6);
    check("fill_valid", DW'(skew_valid), '0);
    drive(0, 0, 1, '0);

    // Random stalls, gaps and tiles of at least 4 beats; model-checked only
    tb = 0;
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 3) != 0);
      v = 1'($urandom_range(0, 1));
      l = v ? (tb >= 3 && $urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
      drive(v, l, e, {8{$urandom()}});
      if (v && e) tb = l ? 0 : tb + 1;
    end
    for (int i = 0; i < 30; i++) drive(0, 0, 1, '0);
    // Close the open tile so the pipeline empties
    drive(1, 1, 1, mkrow(16'h5000));
    for (int i = 0; i < 20; i++) drive(0, 0, 1, '0);
    check("final_busy", DW'(busy), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
